fir_output_requantizer: RTL and testbench
=========================================

# fir_output_requantizer

Output stage for the 9-tap FIR filters. It accepts the 40-bit full-precision filter result and applies round-half-up scaling by 2^SHIFT. It then saturates the result to a 17-bit sample and buffers it in a small FIFO behind a valid/ready stream. It sits between the filter output and the downstream sample consumer. It also reports dropped inputs and saturation events.

## Interface
- IN_W, 40: input sample width, two's complement.
- OUT_W, 17: output sample width, two's complement.
- SHIFT, 15: right-shift applied after rounding; range 1..IN_W-2.
- DEPTH, 4: FIFO depth; power of two, at least 2.
- clock95  in  1  sole clock; all state updates on its rising edge.
- reset95  in  1  asynchronous, active-low reset.
- in_valid95  in  1  input sample present this cycle.
- in_data95  in  IN_W  filter result, signed.
- in_ready95  out  1  block can accept a sample this cycle.
- out_valid95  out  1  out_data95 holds a valid sample.
- out_data95  out  OUT_W  requantized sample, signed.
- out_ready95  in  1  consumer takes the sample this cycle.
- clear95  in  1  synchronous clear of the status outputs.
- drop95  out  1  sticky flag: a sample arrived while in_ready95 was low.
- sat_count95  out  16  number of accepted samples that saturated; holds at 0xFFFF.

## Operation
- Accept occurs when in_valid95 && in_ready95.
- Arithmetic, done at IN_W+1 bits:
  - r = (in_data95 + 2^(SHIFT-1)) >>> SHIFT, with an arithmetic shift.
  - This is round-half-toward-+inf.
- Saturation:
  - r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1 (65535).
  - r < -2^(OUT_W-1) gives -2^(OUT_W-1) (-65536).
  - Any other r passes through unchanged.
  - A saturated accept increments sat_count95 unless the count is 0xFFFF.
- Pipeline: one register stage (pipe_valid, pipe_data) holds the rounded and saturated value. The next cycle writes it into the FIFO.
- FIFO:
  - DEPTH entries, circular read and write pointers with wrap-around, plus an occupancy count.
  - Pointers wrap modulo DEPTH.
  - Writing and reading in the same cycle leaves the count unchanged.
  - A write into a full FIFO never happens, because in_ready95 guarantees it.
- in_ready95 = (count + pipe_valid) < DEPTH. It is combinational from registered state only, with no path from in_valid95 or out_ready95.
- Output:
  - out_valid95 = (count != 0).
  - out_data95 = the FIFO head entry.
  - A pop occurs on out_valid95 && out_ready95.
  - out_data95 stays stable while out_valid95 is high and out_ready95 is low.
- Drop: in_valid95 && !in_ready95 discards the sample and sets drop95. The filter cannot stall, so discarding is the defined behaviour.
- clear95:
  - Zeroes drop95 and sat_count95 on the next edge.
  - It beats a same-cycle drop or saturation event.
  - The FIFO and pipeline are unaffected.
- Reset, asynchronous on reset95 low:
  - Pointers, count and pipe_valid go to 0.
  - out_valid95 = 0, out_data95 = 0, in_ready95 = 1, drop95 = 0, sat_count95 = 0.
  - Reset mid-operation discards all buffered samples immediately.
  - The block is usable on the first rising edge after reset95 returns high.

## Timing
- Latency with the FIFO empty and out_ready95 high:
  - A sample accepted in cycle N is in the pipe register after edge N.
  - It is in the FIFO after edge N+1.
  - out_valid95 is high during cycle N+2.
- Throughput: one sample per cycle sustained while out_ready95 stays high.
- Backpressure: after DEPTH samples are accepted with no pops, in_ready95 is low from the following cycle. This counts the sample still in the pipe.
- Flags:
  - drop95 is high from the edge after the dropped cycle.
  - sat_count95 updates at the accept edge.
- A pop in cycle M frees a slot. in_ready95 rises in cycle M+1.

## Test plan
- Reset, then the input sequence 3276800, 16384, -16384, -16385 with out_ready95=1.
  - Required outputs in order: 100, 1, 0, -1.
  - First out_valid95 two cycles after the first accept.
  - sat_count95 stays 0.
- Input 2^35, then -2^35.
  - Required outputs: 65535, then -65536.
  - sat_count95 = 2.
  - Then pulse clear95 and require sat_count95 = 0.
- Hold out_ready95=0 and drive 6 consecutive valid samples 1..6 (each scaled by 2^15).
  - in_ready95 falls after 4 accepts.
  - Samples 5 and 6 are dropped and drop95 = 1.
  - Then raise out_ready95 and require outputs 1, 2, 3, 4 in order, with out_data95 stable while stalled.
- Continuous 20-sample ramp with out_ready95 toggling every cycle and the input throttled on in_ready95.
  - No loss, no duplication, order preserved.
  - Check that pointers wrap at least twice.
- Assert reset95 low mid-stream with 3 samples buffered.
  - out_valid95 drops to 0 asynchronously, without waiting for an edge.
  - After release, a new sample 32768 produces output 1 with nothing stale ahead of it.
- Simultaneous clear95 with a saturating accept.
  - sat_count95 = 0 the next cycle.
  - The saturated sample is still output as 65535.

Source files
------------

// File: rtl/fir_output_requantizer.sv
// Output stage for the 9-tap FIR filters: rounds and scales the 40-bit result,
// saturates it to a 17-bit sample and buffers it behind a valid/ready stream.
module fir_output_requantizer #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 17,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic             clock95,
    input  logic             reset95,
    input  logic             in_valid95,
    input  logic [IN_W-1:0]  in_data95,
    output logic             in_ready95,
    output logic             out_valid95,
    output logic [OUT_W-1:0] out_data95,
    input  logic             out_ready95,
    input  logic             clear95,
    output logic             drop95,
    output logic [15:0]      sat_count95
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic signed [IN_W:0] HALF =
        {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [IN_W:0] SAT_MAX =
        {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN =
        {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    accept;
    logic signed [IN_W:0]    wide;
    logic signed [IN_W:0]    rounded;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        sat_value;

    logic                    pipe_valid;
    logic [OUT_W-1:0]        pipe_data;

    logic [OUT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        occupancy;
    logic                    push;
    logic                    pop;

    // The sample sitting in the pipe register already owns a FIFO slot.
    assign occupancy   = count + CNT_W'(pipe_valid);
    assign in_ready95  = occupancy < CNT_W'(DEPTH);
    assign accept      = in_valid95 && in_ready95;

    assign wide    = $signed({in_data95[IN_W-1], in_data95}) + HALF;
    assign rounded = wide >>> SHIFT;
    assign sat_hi  = rounded > SAT_MAX;
    assign sat_lo  = rounded < SAT_MIN;

    always_comb begin
        sat_value = rounded[OUT_W-1:0];
        if (sat_hi)
            sat_value = {1'b0, {(OUT_W-1){1'b1}}};
        else if (sat_lo)
            sat_value = {1'b1, {(OUT_W-1){1'b0}}};
    end

    always_ff @(posedge clock95 or negedge reset95) begin
        if (!reset95) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
        end else begin
            pipe_valid <= accept;
            if (accept)
                pipe_data <= sat_value;
        end
    end

    assign push        = pipe_valid;
    assign out_valid95 = (count != '0);
    assign pop         = out_valid95 && out_ready95;
    assign out_data95  = out_valid95 ? mem[rd_ptr] : '0;

    always_ff @(posedge clock95 or negedge reset95) begin
        if (!reset95) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; out_data95 is masked while the FIFO is empty.
    always_ff @(posedge clock95) begin
        if (push)
            mem[wr_ptr] <= pipe_data;
    end

    always_ff @(posedge clock95 or negedge reset95) begin
        if (!reset95) begin
            drop95      <= 1'b0;
            sat_count95 <= '0;
        end else if (clear95) begin
            drop95      <= 1'b0;
            sat_count95 <= '0;
        end else begin
            if (in_valid95 && !in_ready95)
                drop95 <= 1'b1;
            if (accept && (sat_hi || sat_lo) && (sat_count95 != 16'hFFFF))
                sat_count95 <= sat_count95 + 16'd1;
        end
    end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: a vector table for the arithmetic,
// plus hand-written sequences for backpressure, wrap-around, reset and clear.
module tb_fir_output_requantizer;

    logic               clock95 = 1'b0;
    logic               reset95;
    logic               in_valid95;
    logic [39:0]        in_data95;
    logic               in_ready95;
    logic               out_valid95;
    logic [16:0]        out_data95;
    logic               out_ready95;
    logic               clear95;
    logic               drop95;
    logic [15:0]        sat_count95;

    int passed = 0;
    int total  = 0;

    logic signed [16:0] got_q[$];
    int                 wraps = 0;
    logic [1:0]         prev_wr = '0;

    typedef struct {
        logic signed [39:0] din;
        logic signed [16:0] expv;
        logic               sat;
    } vec_t;

    vec_t vecs[11];

    fir_output_requantizer #(
        .IN_W(40), .OUT_W(17), .SHIFT(15), .DEPTH(4)
    ) dut (
        .clock95    (clock95),
        .reset95    (reset95),
        .in_valid95 (in_valid95),
        .in_data95  (in_data95),
        .in_ready95 (in_ready95),
        .out_valid95(out_valid95),
        .out_data95 (out_data95),
        .out_ready95(out_ready95),
        .clear95    (clear95),
        .drop95     (drop95),
        .sat_count95(sat_count95)
    );

    always #5 clock95 = ~clock95;

    // Record every pop, sampled mid-cycle ahead of the edge that performs it.
    always @(negedge clock95) begin
        if (reset95 && out_valid95 && out_ready95)
            got_q.push_back($signed(out_data95));
        if (reset95 && dut.wr_ptr != prev_wr && dut.wr_ptr == 2'd0)
            wraps++;
        prev_wr = dut.wr_ptr;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] expv);
        total++;
        if (act === expv)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Inputs are held for one cycle; returns 1 time unit after the next edge.
    task automatic apply_stimulus(input logic v, input logic [39:0] d, input logic rdy);
        in_valid95  = v;
        in_data95   = d;
        out_ready95 = rdy;
        @(posedge clock95);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 40'd0, rdy);
    endtask

    initial begin
        int sat_exp;
        int sent;
        int cyc;
        logic [16:0] held;

        vecs[0]  = '{40'sd3276800,         17'sd100,    1'b0};
        vecs[1]  = '{40'sd16384,           17'sd1,      1'b0};
        vecs[2]  = '{-40'sd16384,          17'sd0,      1'b0};
        vecs[3]  = '{-40'sd16385,          -17'sd1,     1'b0};
        vecs[4]  = '{40'sd34359738368,     17'sd65535,  1'b1};
        vecs[5]  = '{-40'sd34359738368,    -17'sd65536, 1'b1};
        vecs[6]  = '{40'sd2147450880,      17'sd65535,  1'b0};
        vecs[7]  = '{40'sd2147467264,      17'sd65535,  1'b1};
        vecs[8]  = '{-40'sd2147483648,     -17'sd65536, 1'b0};
        vecs[9]  = '{-40'sd2147500032,     -17'sd65536, 1'b0};
        vecs[10] = '{-40'sd2147500033,     -17'sd65536, 1'b1};

        reset95     = 1'b0;
        in_valid95  = 1'b0;
        in_data95   = '0;
        out_ready95 = 1'b1;
        clear95     = 1'b0;
        repeat (3) @(posedge clock95);
        @(negedge clock95);
        reset95 = 1'b1;
        @(posedge clock95);
        #1;

        check_output("reset out_valid", out_valid95, 0);
        check_output("reset out_data", $signed(out_data95), 0);
        check_output("reset in_ready", in_ready95, 1);
        check_output("reset drop", drop95, 0);
        check_output("reset sat_count", sat_count95, 0);

        // Vector table streamed back-to-back with the consumer always ready.
        got_q.delete();
        sat_exp = 0;
        for (int i = 0; i < 11; i++) begin
            check_output($sformatf("table in_ready %0d", i), in_ready95, 1);
            apply_stimulus(1'b1, vecs[i].din, 1'b1);
            if (vecs[i].sat)
                sat_exp++;
            if (i == 0)
                check_output("latency N+1 out_valid", out_valid95, 0);
            if (i == 1) begin
                check_output("latency N+2 out_valid", out_valid95, 1);
                check_output("latency N+2 out_data", $signed(out_data95), vecs[0].expv);
            end
            if (i == 3)
                check_output("no sat after first four", sat_count95, 0);
        end
        idle(4, 1'b1);
        check_output("table output count", got_q.size(), 11);
        for (int i = 0; i < 11; i++)
            if (i < got_q.size())
                check_output($sformatf("table out %0d", i), got_q[i], vecs[i].expv);
        check_output("table sat_count", sat_count95, sat_exp);

        clear95 = 1'b1;
        idle(1, 1'b1);
        clear95 = 1'b0;
        check_output("clear sat_count", sat_count95, 0);

        // Backpressure: six samples with the consumer stalled.
        got_q.delete();
        for (int k = 1; k <= 6; k++) begin
            check_output($sformatf("stall in_ready before %0d", k), in_ready95, (k <= 4) ? 1 : 0);
            if (k == 5)
                check_output("drop before overflow", drop95, 0);
            apply_stimulus(1'b1, 40'(k) << 15, 1'b0);
        end
        check_output("drop after overflow", drop95, 1);
        held = out_data95;
        idle(3, 1'b0);
        check_output("stalled out_valid", out_valid95, 1);
        check_output("stalled head", $signed(out_data95), 1);
        check_output("stalled stable", out_data95, held);
        check_output("stalled no pops", got_q.size(), 0);
        idle(6, 1'b1);
        check_output("stall drain count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size())
                check_output($sformatf("stall drain %0d", i), got_q[i], i + 1);
        clear95 = 1'b1;
        idle(1, 1'b1);
        clear95 = 1'b0;
        check_output("clear drop", drop95, 0);

        // Ramp with a toggling consumer and a producer throttled on in_ready.
        got_q.delete();
        wraps = 0;
        sent  = 0;
        cyc   = 0;
        while (got_q.size() < 20 && cyc < 400) begin
            if (sent < 20 && in_ready95) begin
                apply_stimulus(1'b1, 40'(sent + 1) << 15, cyc[0]);
                sent++;
            end else begin
                apply_stimulus(1'b0, 40'd0, cyc[0]);
            end
            cyc++;
        end
        check_output("ramp within budget", (cyc < 400) ? 1 : 0, 1);
        check_output("ramp count", got_q.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < got_q.size())
                check_output($sformatf("ramp out %0d", i), got_q[i], i + 1);
        check_output("ramp pointer wraps >= 2", (wraps >= 2) ? 1 : 0, 1);
        check_output("ramp no drop", drop95, 0);

        // Reset while three samples are buffered.
        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b1, 40'(k + 7) << 15, 1'b0);
        idle(1, 1'b0);
        check_output("pre-reset out_valid", out_valid95, 1);
        #2;
        reset95 = 1'b0;
        #1;
        check_output("async reset out_valid", out_valid95, 0);
        check_output("async reset out_data", $signed(out_data95), 0);
        check_output("async reset in_ready", in_ready95, 1);
        @(negedge clock95);
        reset95 = 1'b1;
        @(posedge clock95);
        #1;
        got_q.delete();
        apply_stimulus(1'b1, 40'd32768, 1'b1);
        idle(4, 1'b1);
        check_output("post-reset count", got_q.size(), 1);
        if (got_q.size() > 0)
            check_output("post-reset out", got_q[0], 1);

        // Clear coinciding with a saturating accept.
        got_q.delete();
        apply_stimulus(1'b1, 40'sd34359738368, 1'b1);
        check_output("sat before clear", sat_count95, 1);
        clear95 = 1'b1;
        apply_stimulus(1'b1, 40'sd34359738368, 1'b1);
        clear95 = 1'b0;
        check_output("clear beats sat", sat_count95, 0);
        idle(4, 1'b1);
        check_output("clear-sat count", got_q.size(), 2);
        if (got_q.size() > 1)
            check_output("clear-sat sample", got_q[1], 65535);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
